// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state, access-size constants and byte-enable helper for the LSU
package mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    be_mask = 4'b0001 << off;
      SZ_H:    be_mask = 4'b0011 << off;
      default: be_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - picks the addressed byte/halfword lane from a read word and extends it
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_funct3)
      F3_LB:   o_value = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_value = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_value = {24'd0, w_byte};
      F3_LHU:  o_value = {16'd0, w_half};
      F3_LW:   o_value = i_rdata;
      default: o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - pipeline memory stage: one data-bus access per op with fault and timeout handling
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_res,
  input  logic [31:0] ex_store_data,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_e r_state, w_next;

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_dmem_addr, r_dmem_wdata, r_wb_data;
  logic [3:0]    r_dmem_be;
  logic          r_dmem_we, r_regwrite, r_mis, r_berr, r_is_load;
  logic [4:0]    r_rd;
  logic [1:0]    r_off;
  logic [2:0]    r_funct3;

  logic        w_accept, w_is_mem, w_bad_f3, w_fault, w_mis, w_to_busy, w_timeout;
  logic [31:0] w_wdata, w_load_val;

  // Undefined encodings: loads 011/110/111, stores anything but 000/001/010.
  always_comb begin
    w_is_mem = ex_memread | ex_memwrite;
    if (ex_memwrite)
      w_bad_f3 = ex_funct3[2] | (ex_funct3[1:0] == 2'b11);
    else
      w_bad_f3 = (ex_funct3 == 3'b011) | (ex_funct3 == 3'b110) | (ex_funct3 == 3'b111);
    w_fault   = (ex_memread & ex_memwrite) | (w_is_mem & w_bad_f3);
    w_mis     = w_is_mem & ~w_fault &
                (((ex_funct3[1:0] == SZ_H) & ex_res[0]) |
                 ((ex_funct3[1:0] == SZ_W) & (ex_res[1:0] != 2'b00)));
    w_accept  = ex_valid & (r_state == IDLE);
    w_to_busy = w_is_mem & ~w_fault & ~w_mis;
    w_timeout = (r_state == BUSY) & ~dmem_ack & (r_cnt == TO_LAST);
    case (ex_funct3[1:0])
      SZ_B:    w_wdata = {4{ex_store_data[7:0]}};
      SZ_H:    w_wdata = {2{ex_store_data[15:0]}};
      default: w_wdata = ex_store_data;
    endcase
  end

  load_align u_load_align (
    .i_rdata  (dmem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_value  (w_load_val)
  );

  always_ff @(posedge clk) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_to_busy ? BUSY : RESP;
      BUSY:    if (dmem_ack || w_timeout) w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ex_ready    = (r_state == IDLE);
    dmem_req    = (r_state == BUSY);
    wb_valid    = (r_state == RESP);
    misalign    = (r_state == RESP) & r_mis;
    bus_err     = (r_state == RESP) & r_berr;
    wb_regwrite = (r_state == RESP) & r_regwrite & ~r_mis & ~r_berr;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_cnt        <= '0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_be    <= '0;
      r_dmem_we    <= 1'b0;
      r_wb_data    <= '0;
      r_rd         <= '0;
      r_regwrite   <= 1'b0;
      r_mis        <= 1'b0;
      r_berr       <= 1'b0;
      r_is_load    <= 1'b0;
      r_off        <= '0;
      r_funct3     <= '0;
    end else begin
      if (w_accept) begin
        r_cnt      <= '0;
        r_wb_data  <= ex_res;
        r_rd       <= ex_rd;
        r_regwrite <= ex_regwrite & ~ex_memwrite;
        r_mis      <= w_mis;
        r_berr     <= w_fault;
        r_is_load  <= ex_memread;
        r_off      <= ex_res[1:0];
        r_funct3   <= ex_funct3;
        if (w_to_busy) begin
          r_dmem_addr  <= {ex_res[31:2], 2'b00};
          r_dmem_we    <= ex_memwrite;
          r_dmem_be    <= be_mask(ex_funct3[1:0], ex_res[1:0]);
          r_dmem_wdata <= w_wdata;
        end
      end
      if (r_state == BUSY) begin
        if (dmem_ack) begin
          if (r_is_load) r_wb_data <= w_load_val;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout) r_berr <= 1'b1;
        end
      end
    end
  end

  assign dmem_addr  = r_dmem_addr;
  assign dmem_we    = r_dmem_we;
  assign dmem_be    = r_dmem_be;
  assign dmem_wdata = r_dmem_wdata;
  assign wb_data    = r_wb_data;
  assign wb_rd      = r_rd;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed and randomized checks of mem_stage_lsu against a behavioural model
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        Rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_res, ex_store_data;
  logic        ex_memread, ex_memwrite;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite, misalign, bus_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Rst(Rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_res(ex_res), .ex_store_data(ex_store_data),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .misalign(misalign), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ack_dly: BUSY cycle index (0 = first req cycle) in which ack is given; negative = never.
  task automatic op(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] res,
                    input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                    input int ack_dly, input logic [31:0] rdata);
    int          nbytes, off, bits, req_cycles;
    bit          is_mem, vload, vstore, fault, mis, busy, acked;
    longint      v;
    logic [31:0] e_be, e_wd, e_data;
    is_mem = mr | mw;
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bits   = 8 * nbytes;
    off    = int'(res % 4);
    vload  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    vstore = (f3 <= 3'd2);
    fault  = (mr && mw) || (mr && !vload) || (mw && !vstore);
    mis    = !fault && is_mem && ((off % nbytes) != 0);
    busy   = is_mem && !fault && !mis;
    acked  = busy && (ack_dly >= 0) && (ack_dly < TIMEOUT);

    chk("ex_ready_idle", ex_ready, 1);
    ex_valid = 1; ex_memread = mr; ex_memwrite = mw; ex_funct3 = f3; ex_res = res;
    ex_store_data = sd; ex_rd = rd; ex_regwrite = rw;
    @(negedge clk);
    ex_valid = 0; ex_res = $urandom; ex_store_data = $urandom; ex_rd = 5'($urandom);
    ex_funct3 = 3'($urandom); ex_memread = 1'($urandom); ex_memwrite = 1'($urandom);
    ex_regwrite = 1'($urandom);

    e_data = res;
    if (!busy) begin
      chk("no_dmem_req", dmem_req, 0);
    end else begin
      e_be = ((32'd1 << nbytes) - 1) << off;
      e_wd = (nbytes == 1) ? (sd % 256) * 32'h0101_0101 :
             (nbytes == 2) ? (sd % 65536) * 32'h0001_0001 : sd;
      req_cycles = acked ? ack_dly + 1 : TIMEOUT;
      for (int k = 0; k < req_cycles; k++) begin
        chk("dmem_req_busy", dmem_req, 1);
        chk("dmem_addr", dmem_addr, res - (res % 4));
        chk("dmem_be", dmem_be, e_be);
        chk("dmem_we", dmem_we, mw);
        if (mw) chk("dmem_wdata", dmem_wdata, e_wd);
        if (k == ack_dly) begin dmem_ack = 1; dmem_rdata = rdata; end
        @(negedge clk);
        dmem_ack = 0; dmem_rdata = $urandom;
      end
      if (mr && acked) begin
        v = (longint'(rdata) >> (8 * off)) % (longint'(1) << bits);
        if (!f3[2] && bits < 32 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        e_data = v[31:0];
      end
    end

    chk("wb_valid", wb_valid, 1);
    chk("dmem_req_resp", dmem_req, 0);
    chk("wb_rd", wb_rd, rd);
    chk("misalign", misalign, mis);
    chk("bus_err", bus_err, fault || (busy && !acked));
    chk("wb_regwrite", wb_regwrite, rw && !mw && !fault && !mis && !(busy && !acked));
    if (!is_mem || (mr && acked)) chk("wb_data", wb_data, e_data);
    @(negedge clk);
    chk("wb_valid_drop", wb_valid, 0);
    chk("misalign_drop", misalign, 0);
    chk("bus_err_drop", bus_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cls, dly;
    logic [2:0] f3;
    Rst = 1; ex_valid = 0; ex_res = 0; ex_store_data = 0; ex_memread = 0; ex_memwrite = 0;
    ex_funct3 = 0; ex_rd = 0; ex_regwrite = 0; dmem_ack = 0; dmem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_be", dmem_be, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_regwrite", wb_regwrite, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_bus_err", bus_err, 0);
    Rst = 0;
    @(negedge clk);

    op(1, 0, 3'b010, 32'h100, 0, 5'd1, 1, 0, 32'hDEAD_BEEF);
    op(1, 0, 3'b000, 32'h103, 0, 5'd2, 1, 1, 32'h80FF_FF7F);
    op(1, 0, 3'b100, 32'h103, 0, 5'd3, 1, 2, 32'h80FF_FF7F);
    op(0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 5'd4, 1, 0, 0);
    op(1, 0, 3'b010, 32'h101, 0, 5'd5, 1, 0, 0);
    op(1, 0, 3'b010, 32'h200, 0, 5'd6, 1, -1, 0);
    op(1, 0, 3'b001, 32'h206, 0, 5'd7, 1, TIMEOUT - 1, 32'h8001_7FFF);
    op(0, 0, 3'b000, 32'h55, 0, 5'd8, 1, 0, 0);
    op(1, 1, 3'b010, 32'h300, 0, 5'd9, 1, 0, 0);
    op(1, 0, 3'b011, 32'h300, 0, 5'd10, 1, 0, 0);
    op(0, 1, 3'b100, 32'h300, 0, 5'd11, 0, 0, 0);

    // An ack while idle must not start or complete anything.
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
    chk("idle_ack_req", dmem_req, 0);
    chk("idle_ack_wb", wb_valid, 0);
    chk("idle_ack_ready", ex_ready, 1);

    // Reset during BUSY, coinciding with an ack: access is abandoned silently.
    ex_valid = 1; ex_memread = 1; ex_memwrite = 0; ex_funct3 = 3'b010; ex_res = 32'h400;
    ex_rd = 5'd12; ex_regwrite = 1;
    @(negedge clk);
    ex_valid = 0;
    repeat (3) @(negedge clk);
    chk("midrst_req_before", dmem_req, 1);
    Rst = 1; dmem_ack = 1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    Rst = 0; dmem_ack = 0;
    chk("midrst_ready", ex_ready, 1);
    chk("midrst_req", dmem_req, 0);
    chk("midrst_wb", wb_valid, 0);
    chk("midrst_berr", bus_err, 0);
    @(negedge clk);
    chk("midrst_wb_after", wb_valid, 0);
    chk("midrst_berr_after", bus_err, 0);

    for (int i = 0; i < 150; i++) begin
      cls = $urandom_range(0, 9);
      f3  = (($urandom_range(0, 4)) == 0) ? 3'($urandom) :
            ((cls >= 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      dly = ($urandom_range(0, 9) == 0) ? TIMEOUT + 4 : $urandom_range(0, 3);
      op(cls >= 2 && cls <= 5 || cls == 9, cls >= 6, f3, $urandom, $urandom,
         5'($urandom), 1'($urandom), dly, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
